// File: rtl/dram_cmd_responder.sv
// dram_cmd_responder: device-side DRAM model with per-bank open-row FSMs, tRCD/tRP/tRFC timing,
// a CL-deep read pipeline and sticky violation codes. Optional macro: DRAM_RESP_STRICT_EN.
module dram_cmd_responder #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int T_RCD           = 2,
  parameter int T_RP            = 2,
  parameter int T_RFC           = 8,
  parameter int CL              = 2
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic [1:0]                         cmd,
  input  logic                               bank_en,
  input  logic                               row_en,
  input  logic                               col_en,
  input  logic                               ref_en,
  input  logic                               wr_en,
  input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
  input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
  input  logic [$clog2(NUMBER_OF_COLS)-1:0]  col_id,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               err_clr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic                               busy,
  output logic [NUMBER_OF_BANKS-1:0]         bank_open,
  output logic                               err,
  output logic [2:0]                         err_code
);
  localparam int BW    = $clog2(NUMBER_OF_BANKS);
  localparam int RW    = $clog2(NUMBER_OF_ROWS);
  localparam int TMAX  = (T_RCD > T_RP) ? ((T_RCD > T_RFC) ? T_RCD : T_RFC)
                                        : ((T_RP > T_RFC) ? T_RP : T_RFC);
  localparam int TW    = $clog2(TMAX + 1);
  localparam int DEPTH = NUMBER_OF_BANKS * NUMBER_OF_ROWS * NUMBER_OF_COLS;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    B_IDLE, B_ACTIVATING, B_ACTIVE, B_PRECHARGING, B_REFRESH
  } bank_state_e;

  logic                              is_act, is_col, is_pre, is_ref, is_any;
  logic [NUMBER_OF_BANKS-1:0]        idle_vec, open_vec, actv_vec;
  logic [NUMBER_OF_BANKS-1:0][RW-1:0] row_vec;
  logic                              sel_idle, sel_open, sel_actv, all_idle, row_miss, blocked;
  logic                              act_go, pre_go, ref_go, col_go, rd_go, mem_we;
  logic [RW-1:0]                     sel_row;
  logic [AW-1:0]                     mem_addr;
  logic [2:0]                        viol;
  logic [TW-1:0]                     rfc_q, rfc_d;
  logic                              err_q, err_d;
  logic [2:0]                        code_q, code_d;
  logic [CL-1:0]                     rv_q, rv_d, rz_q, rz_d;
  logic [DATA_WIDTH-1:0]             mem [DEPTH];
  logic [DATA_WIDTH-1:0]             rdata_q [CL];

  assign is_act = (cmd == 2'b00) && bank_en && row_en;
  assign is_col = (cmd == 2'b01) && col_en;
  assign is_pre = (cmd == 2'b11);
  assign is_ref = (cmd == 2'b10) && ref_en;
  assign is_any = is_act || is_col || is_pre || is_ref;
  assign busy   = (rfc_q != '0);

  assign sel_idle = idle_vec[bank_id];
  assign sel_open = open_vec[bank_id];
  assign sel_actv = actv_vec[bank_id];
  assign sel_row  = row_vec[bank_id];
  assign all_idle = &idle_vec;
  assign row_miss = (row_id != sel_row);

  assign act_go = is_act && !busy && sel_idle;
  assign pre_go = is_pre && !busy && sel_open;
  assign ref_go = is_ref && !busy && all_idle;
  assign col_go = is_col && !busy && sel_open;
`ifdef DRAM_RESP_STRICT_EN
  assign blocked = row_miss;
`else
  assign blocked = 1'b0;
`endif
  assign mem_we   = col_go && wr_en && !blocked;
  assign rd_go    = col_go && !wr_en;
  // Column accesses always address the bank's latched open row, never row_id.
  assign mem_addr = AW'((int'(bank_id) * NUMBER_OF_ROWS + int'(sel_row)) * NUMBER_OF_COLS
                        + int'(col_id));

  always_comb begin
    viol = 3'b000;
    if (busy && is_any)                 viol = 3'b101;
    else if (is_act && !sel_idle)       viol = 3'b001;
    else if (is_col && !sel_open)       viol = 3'b010;
    else if (is_col && row_miss)        viol = 3'b110;
    else if (is_pre && sel_actv)        viol = 3'b011;
    else if (is_ref && !all_idle)       viol = 3'b100;

    err_d  = err_q;
    code_d = code_q;
    if (err_clr) begin
      err_d  = 1'b0;
      code_d = 3'b000;
    end
    if ((viol != 3'b000) && (!err_q || err_clr)) begin
      err_d  = 1'b1;
      code_d = viol;
    end

    rfc_d = rfc_q;
    if (ref_go)    rfc_d = TW'(T_RFC);
    else if (busy) rfc_d = rfc_q - 1'b1;

    rv_d = (rv_q << 1) | CL'(rd_go);
    rz_d = (rz_q << 1) | CL'(rd_go && blocked);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      rfc_q  <= '0;
      err_q  <= 1'b0;
      code_q <= 3'b000;
      rv_q   <= '0;
      rz_q   <= '0;
    end else begin
      rfc_q  <= rfc_d;
      err_q  <= err_d;
      code_q <= code_d;
      rv_q   <= rv_d;
      rz_q   <= rz_d;
    end
  end

  for (genvar gi = 0; gi < NUMBER_OF_BANKS; gi++) begin : g_bank
    bank_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] row_q, row_d;
    logic          hit;

    assign hit = (bank_id == BW'(gi));

    // Timers load with (t - 1) so the bank changes state exactly t cycles after the command.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      row_d   = row_q;
      case (state_q)
        B_IDLE: begin
          if (act_go && hit) begin
            row_d   = row_id;
            timer_d = TW'(T_RCD - 1);
            state_d = (T_RCD > 1) ? B_ACTIVATING : B_ACTIVE;
          end else if (ref_go) begin
            state_d = B_REFRESH;
          end
        end
        B_ACTIVATING, B_PRECHARGING: begin
          if (timer_q <= TW'(1)) begin
            timer_d = '0;
            state_d = (state_q == B_ACTIVATING) ? B_ACTIVE : B_IDLE;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        B_ACTIVE: begin
          if (pre_go && hit) begin
            timer_d = TW'(T_RP - 1);
            state_d = (T_RP > 1) ? B_PRECHARGING : B_IDLE;
          end
        end
        B_REFRESH: begin
          if (rfc_q <= TW'(1)) state_d = B_IDLE;
        end
        default: state_d = B_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
        state_q <= B_IDLE;
        timer_q <= '0;
        row_q   <= '0;
      end else begin
        state_q <= state_d;
        timer_q <= timer_d;
        row_q   <= row_d;
      end
    end

    assign idle_vec[gi] = (state_q == B_IDLE);
    assign open_vec[gi] = (state_q == B_ACTIVE);
    assign actv_vec[gi] = (state_q == B_ACTIVATING);
    assign row_vec[gi]  = row_q;
  end

  // Array and read data path carry no reset so they map onto block RAM plus plain registers.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= wr_data;
    rdata_q[0] <= mem[mem_addr];
    for (int i = 1; i < CL; i++) rdata_q[i] <= rdata_q[i-1];
  end

  assign rd_valid  = rv_q[CL-1];
  assign rd_data   = (rv_q[CL-1] && !rz_q[CL-1]) ? rdata_q[CL-1] : '0;
  assign bank_open = open_vec;
  assign err       = err_q;
  assign err_code  = code_q;
endmodule

// File: tb/tb_dram_cmd_responder.sv
// Testbench for dram_cmd_responder: directed steps plus random commands, checked against a
// timestamp-based bank/refresh/read model kept in the bench.
module tb_dram_cmd_responder;
  localparam int NB = 8, NR = 128, NC = 8, DW = 8;
  localparam int TRCD = 2, TRP = 2, TRFC = 8, CL = 2;
  localparam int BW = 3, RW = 7, CW = 3;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [1:0]    cmd;
  logic          bank_en, row_en, col_en, ref_en, wr_en, err_clr;
  logic [BW-1:0] bank_id;
  logic [RW-1:0] row_id;
  logic [CW-1:0] col_id;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy, err;
  logic [NB-1:0] bank_open;
  logic [2:0]    err_code;

  dram_cmd_responder #(
    .NUMBER_OF_BANKS(NB), .NUMBER_OF_ROWS(NR), .NUMBER_OF_COLS(NC), .DATA_WIDTH(DW),
    .T_RCD(TRCD), .T_RP(TRP), .T_RFC(TRFC), .CL(CL)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cmd(cmd), .bank_en(bank_en), .row_en(row_en),
    .col_en(col_en), .ref_en(ref_en), .wr_en(wr_en), .bank_id(bank_id), .row_id(row_id),
    .col_id(col_id), .wr_data(wr_data), .err_clr(err_clr), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .bank_open(bank_open), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: each bank remembers when it was opened/closed; status follows from elapsed cycles.
  bit            m_open [NB];
  int            m_row  [NB];
  int            m_act  [NB];
  int            m_pre  [NB];
  int            m_ref;
  logic [DW-1:0] m_mem [int];
  bit            m_err;
  logic [2:0]    m_code;
  bit            exp_rd_valid [int];
  bit            exp_rd_known [int];
  logic [DW-1:0] exp_rd_data  [int];

  // 0 idle, 1 activating, 2 active, 3 precharging
  function automatic int bank_status(int b, int c);
    if (m_open[b]) return (c - m_act[b] >= TRCD) ? 2 : 1;
    return (c - m_pre[b] >= TRP) ? 0 : 3;
  endfunction

  function automatic bit busy_at(int c);
    return (c > m_ref) && (c <= m_ref + TRFC);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = 0;
      m_act[b]  = cyc - 1000;
      m_pre[b]  = cyc - 1000;
    end
    m_ref  = cyc - 1000;
    m_err  = 1'b0;
    m_code = 3'b000;
    exp_rd_valid.delete();
    exp_rd_known.delete();
    exp_rd_data.delete();
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_cmd();
    int         c, b, st, addr;
    bit         is_act, is_col, is_pre, is_ref, mism, blk, any_busy_bank;
    logic [2:0] code;
    c      = cyc;
    b      = int'(bank_id);
    code   = 3'b000;
    is_act = (cmd == 2'b00) && bank_en && row_en;
    is_col = (cmd == 2'b01) && col_en;
    is_pre = (cmd == 2'b11);
    is_ref = (cmd == 2'b10) && ref_en;
    st     = bank_status(b, c);
    if ((is_act || is_col || is_pre || is_ref) && busy_at(c)) begin
      code = 3'b101;
    end else if (is_act) begin
      if (st != 0) code = 3'b001;
      else begin
        m_open[b] = 1'b1;
        m_row[b]  = int'(row_id);
        m_act[b]  = c;
      end
    end else if (is_col) begin
      if (st != 2) code = 3'b010;
      else begin
        mism = (int'(row_id) != m_row[b]);
        if (mism) code = 3'b110;
`ifdef DRAM_RESP_STRICT_EN
        blk = mism;
`else
        blk = 1'b0;
`endif
        addr = (b * NR + m_row[b]) * NC + int'(col_id);
        if (wr_en) begin
          if (!blk) m_mem[addr] = wr_data;
        end else begin
          exp_rd_valid[c + CL] = 1'b1;
          if (blk) begin
            exp_rd_known[c + CL] = 1'b1;
            exp_rd_data[c + CL]  = '0;
          end else if (m_mem.exists(addr)) begin
            exp_rd_known[c + CL] = 1'b1;
            exp_rd_data[c + CL]  = m_mem[addr];
          end else begin
            exp_rd_known[c + CL] = 1'b0;
          end
        end
      end
    end else if (is_pre) begin
      if (st == 1) code = 3'b011;
      else if (st == 2) begin
        m_open[b] = 1'b0;
        m_pre[b]  = c;
      end
    end else if (is_ref) begin
      any_busy_bank = 1'b0;
      for (int k = 0; k < NB; k++) if (bank_status(k, c) != 0) any_busy_bank = 1'b1;
      if (any_busy_bank) code = 3'b100;
      else m_ref = c;
    end
    if (err_clr) begin
      m_err  = 1'b0;
      m_code = 3'b000;
    end
    if ((code != 3'b000) && (!m_err || err_clr)) begin
      m_err  = 1'b1;
      m_code = code;
    end
  endtask

  task automatic check_outputs(string tag);
    logic [NB-1:0] bo;
    bit            v;
    bo = '0;
    for (int b = 0; b < NB; b++) bo[b] = (bank_status(b, cyc) == 2);
    v = exp_rd_valid.exists(cyc);
    check({tag, ".bank_open"}, 32'(bank_open), 32'(bo));
    check({tag, ".busy"},      32'(busy),      32'(busy_at(cyc)));
    check({tag, ".rd_valid"},  32'(rd_valid),  32'(v));
    if (v && exp_rd_known[cyc]) check({tag, ".rd_data"}, 32'(rd_data), 32'(exp_rd_data[cyc]));
    check({tag, ".err"},       32'(err),       32'(m_err));
    check({tag, ".err_code"},  32'(err_code),  32'(m_code));
  endtask

  task automatic step(string tag, logic [1:0] c_cmd, logic c_be, logic c_re, logic c_ce,
                      logic c_rfe, logic c_we, int b, int r, int col, int d, logic clr);
    cmd     = c_cmd;
    bank_en = c_be;
    row_en  = c_re;
    col_en  = c_ce;
    ref_en  = c_rfe;
    wr_en   = c_we;
    bank_id = BW'(b);
    row_id  = RW'(r);
    col_id  = CW'(col);
    wr_data = DW'(d);
    err_clr = clr;
    $display("%-5s cyc=%0d cmd=%b bank=%0d row=%0d col=%0d we=%b data=%02h clr=%b",
             tag, cyc, cmd, b, r, col, c_we, wr_data, clr);
    model_cmd();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs(tag);
  endtask

  task automatic act(int b, int r, logic clr = 1'b0);
    step("act", 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, b, r, 0, 0, clr);
  endtask
  task automatic colw(int b, int r, int c, int d, logic clr = 1'b0);
    step("colw", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, b, r, c, d, clr);
  endtask
  task automatic colr(int b, int r, int c);
    step("colr", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, b, r, c, 0, 1'b0);
  endtask
  task automatic pre(int b, logic clr = 1'b0);
    step("pre", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, b, 0, 0, 0, clr);
  endtask
  task automatic refc();
    step("ref", 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask
  task automatic nop(logic clr = 1'b0);
    step("nop", 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, clr);
  endtask

  task automatic drive_idle();
    cmd = 2'b10; bank_en = 1'b0; row_en = 1'b0; col_en = 1'b0; ref_en = 1'b0;
    wr_en = 1'b0; bank_id = '0; row_id = '0; col_id = '0; wr_data = '0; err_clr = 1'b0;
  endtask

  // Raise reset mid-cycle, well away from any clock edge, and check outputs clear at once.
  task automatic async_reset(string tag);
    #2;
    rst_b = 1'b1;
    #1;
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".rd_valid"},  32'(rd_valid),  32'd0);
    check({tag, ".bank_open"}, 32'(bank_open), 32'd0);
    check({tag, ".err"},       32'(err),       32'd0);
    drive_idle();
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    model_reset();
    check("rst.rd_valid",  32'(rd_valid),  32'd0);
    check("rst.rd_data",   32'(rd_data),   32'd0);
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.bank_open", 32'(bank_open), 32'd0);
    check("rst.err",       32'(err),       32'd0);
    check("rst.err_code",  32'(err_code),  32'd0);

    // Basic write then read on bank 3, row 5
    act(3, 5);
    nop();
    colw(3, 5, 2, 8'hA5);
    colr(3, 5, 2);
    check("cl.early_valid", 32'(rd_valid), 32'd0);
    nop();
    check("cl.rd_valid",  32'(rd_valid),  32'd1);
    check("cl.rd_data",   32'(rd_data),   32'hA5);
    check("cl.err",       32'(err),       32'd0);
    check("cl.bank_open", 32'(bank_open), 32'h08);

    // COL inside tRCD
    act(1, 9);
    colr(1, 9, 0);
    check("trcd.err",      32'(err),      32'd1);
    check("trcd.err_code", 32'(err_code), 32'b010);
    nop(1'b1);
    check("clr.err",       32'(err),      32'd0);
    check("clr.err_code",  32'(err_code), 32'd0);

    // REF with banks not idle, then a clean refresh and a command during busy
    act(0, 1);
    act(2, 2);
    nop();
    nop();
    pre(0);
    pre(2);
    refc();
    check("ref_notidle.code", 32'(err_code), 32'b100);
    pre(1, 1'b1);
    pre(3);
    nop();
    nop();
    refc();
    check("ref.busy", 32'(busy), 32'd1);
    act(5, 0, 1'b1);
    check("busy_act.code", 32'(err_code), 32'b101);
    nop(1'b1);
    repeat (6) nop();
    check("ref.busy_done", 32'(busy), 32'd0);

    // Back-to-back reads after four writes
    act(4, 20);
    nop();
    for (int i = 0; i < 4; i++) colw(4, 20, i, 8'h10 + i);
    colr(4, 20, 0);
    colr(4, 20, 1);
    check("b2b.d0", 32'(rd_data), 32'h10);
    colr(4, 20, 2);
    check("b2b.d1", 32'(rd_data), 32'h11);
    colr(4, 20, 3);
    check("b2b.d2", 32'(rd_data), 32'h12);
    nop();
    check("b2b.d3", 32'(rd_data), 32'h13);
    nop();
    check("b2b.end", 32'(rd_valid), 32'd0);

    // Row mismatch on an open bank
    colr(4, 21, 1);
    check("miss.code", 32'(err_code), 32'b110);
    nop();
`ifdef DRAM_RESP_STRICT_EN
    check("miss.rd_data", 32'(rd_data), 32'h00);
`else
    check("miss.rd_data", 32'(rd_data), 32'h11);
`endif
    colw(4, 21, 1, 8'h77, 1'b1);
    check("clr_and_viol.code", 32'(err_code), 32'b110);
    nop();
    colr(4, 20, 1);
    nop();
`ifdef DRAM_RESP_STRICT_EN
    check("miss_wr.rd_data", 32'(rd_data), 32'h11);
`else
    check("miss_wr.rd_data", 32'(rd_data), 32'h77);
`endif
    nop(1'b1);

    // Random command stream
    for (int i = 0; i < 400; i++) begin
      step("rnd", 2'($urandom_range(0, 3)), $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
           $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 15) == 0);
    end

    // Reset with reads in flight and an open bank
    async_reset("rst_sync");
    act(2, 1);
    nop();
    colw(2, 1, 0, 8'h3C);
    colr(2, 1, 0);
    colr(2, 1, 0);
    check("inflight.rd_valid", 32'(rd_valid), 32'd1);
    async_reset("rst_rd");
    repeat (CL + 2) nop();

    // Reset during refresh
    refc();
    nop();
    check("rfc.busy_before", 32'(busy), 32'd1);
    async_reset("rst_rfc");
    repeat (3) nop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
